// File: rtl/fpr_wb_pkg.sv
// Shared types for the FP register-file writeback arbiter (fpr_wb_arb, fpr_wb_pick).
package fpr_wb_pkg;

   localparam int FPR_FLEN = 64;
   localparam int NSRC     = 3;

   typedef enum logic [1:0] {SRC_LD, SRC_FPU, SRC_DIV} fpr_wb_src_e;

   typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, ACK} fpr_wb_state_e;

   typedef struct packed {
      logic                wen;
      logic [4:0]          addr;
      logic [FPR_FLEN-1:0] data;
   } fpr_wr_t;

endpackage

// File: rtl/fpr_wb_pick.sv
// Combinational 3-to-2 writeback picker: static ld > fpu > div priority, same-address
// filter on the two candidates, and an override that lifts div to the front.
module fpr_wb_pick
   import fpr_wb_pkg::*;
(
   input  logic [NSRC-1:0]      valid_i,
   input  logic [NSRC-1:0][4:0] addr_i,
   input  logic                 starve_i,
   output logic [NSRC-1:0]      ready_o,
   output logic                 p0_vld_o,
   output fpr_wb_src_e          p0_src_o,
   output logic                 p1_vld_o,
   output fpr_wb_src_e          p1_src_o
);

   fpr_wb_src_e ord [NSRC];
   logic        second_seen;

   always_comb begin
      ord[0] = SRC_LD;
      ord[1] = SRC_FPU;
      ord[2] = SRC_DIV;
      if (starve_i && valid_i[SRC_DIV]) begin
         ord[0] = SRC_DIV;
         ord[1] = SRC_LD;
         ord[2] = SRC_FPU;
      end

      p0_vld_o    = 1'b0;
      p0_src_o    = SRC_LD;
      p1_vld_o    = 1'b0;
      p1_src_o    = SRC_LD;
      second_seen = 1'b0;

      // Only the two highest-ranked valid sources are candidates; a clashing
      // second candidate stalls rather than letting a lower one slip past it.
      for (int i = 0; i < NSRC; i++) begin
         if (valid_i[ord[i]]) begin
            if (!p0_vld_o) begin
               p0_vld_o = 1'b1;
               p0_src_o = ord[i];
            end else if (!second_seen) begin
               second_seen = 1'b1;
               if (addr_i[ord[i]] != addr_i[p0_src_o]) begin
                  p1_vld_o = 1'b1;
                  p1_src_o = ord[i];
               end
            end
         end
      end

      ready_o          = '0;
      ready_o[SRC_LD]  = (p0_vld_o && p0_src_o == SRC_LD)  || (p1_vld_o && p1_src_o == SRC_LD);
      ready_o[SRC_FPU] = (p0_vld_o && p0_src_o == SRC_FPU) || (p1_vld_o && p1_src_o == SRC_FPU);
      ready_o[SRC_DIV] = (p0_vld_o && p0_src_o == SRC_DIV) || (p1_vld_o && p1_src_o == SRC_DIV);
   end

endmodule

// File: rtl/fpr_wb_arb.sv
// FP register-file writeback arbiter and bank-switch sequencer.
// Optional div anti-starvation override is enabled by defining FPR_WB_STARVE_EN.
module fpr_wb_arb
   import fpr_wb_pkg::*;
#(
   parameter int FLEN           = FPR_FLEN,
   parameter int FPR_BANKS_LOG2 = 1,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      ld_valid_i,
   output logic                      ld_ready_o,
   input  logic [4:0]                ld_addr_i,
   input  logic [FLEN-1:0]           ld_data_i,
   input  logic                      fpu_valid_i,
   output logic                      fpu_ready_o,
   input  logic [4:0]                fpu_addr_i,
   input  logic [FLEN-1:0]           fpu_data_i,
   input  logic                      div_valid_i,
   output logic                      div_ready_o,
   input  logic [4:0]                div_addr_i,
   input  logic [FLEN-1:0]           div_data_i,
   input  logic                      bank_sw_req_i,
   input  logic [FPR_BANKS_LOG2-1:0] bank_sw_id_i,
   output logic                      bank_sw_ack_o,
   output logic                      wen0_o,
   output logic                      wen1_o,
   output logic [4:0]                waddr0_o,
   output logic [4:0]                waddr1_o,
   output logic [FLEN-1:0]           wd0_o,
   output logic [FLEN-1:0]           wd1_o,
   output logic                      wen_bank_id_o,
   output logic [FPR_BANKS_LOG2-1:0] wr_bank_id_o,
   output logic                      busy_o
);

   fpr_wb_state_e             state_q;
   fpr_wr_t                   wr0_q, wr0_d, wr1_q, wr1_d;
   logic                      wen_bank_q;
   logic [FPR_BANKS_LOG2-1:0] wr_bank_q;
   logic                      ack_q;
   logic                      busy_q;

   logic                      grant_en;
   logic                      starve;
   logic [NSRC-1:0]           pick_rdy;
   logic                      p0_vld, p1_vld;
   fpr_wb_src_e               p0_src, p1_src;
   fpr_wr_t                   cand [NSRC];

   // Grants only in a quiet IDLE cycle; a pending switch freezes intake at once.
   assign grant_en = !rst_i && (state_q == IDLE) && !bank_sw_req_i;

   assign cand[SRC_LD]  = '{wen: ld_valid_i,  addr: ld_addr_i,  data: FPR_FLEN'(ld_data_i)};
   assign cand[SRC_FPU] = '{wen: fpu_valid_i, addr: fpu_addr_i, data: FPR_FLEN'(fpu_data_i)};
   assign cand[SRC_DIV] = '{wen: div_valid_i, addr: div_addr_i, data: FPR_FLEN'(div_data_i)};

   fpr_wb_pick u_pick (
      .valid_i  ({div_valid_i, fpu_valid_i, ld_valid_i}),
      .addr_i   ({div_addr_i, fpu_addr_i, ld_addr_i}),
      .starve_i (starve),
      .ready_o  (pick_rdy),
      .p0_vld_o (p0_vld),
      .p0_src_o (p0_src),
      .p1_vld_o (p1_vld),
      .p1_src_o (p1_src)
   );

   assign ld_ready_o  = grant_en && pick_rdy[SRC_LD];
   assign fpu_ready_o = grant_en && pick_rdy[SRC_FPU];
   assign div_ready_o = grant_en && pick_rdy[SRC_DIV];

`ifdef FPR_WB_STARVE_EN
   logic [3:0] starve_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (state_q != IDLE || bank_sw_req_i || (div_valid_i && div_ready_o)) begin
         starve_cnt_q <= '0;
      end else if (div_valid_i && !div_ready_o && starve_cnt_q != 4'hF) begin
         starve_cnt_q <= starve_cnt_q + 4'd1;
      end
   end

   assign starve = (starve_cnt_q >= 4'(STARVE_LIMIT - 1));
`else
   assign starve = 1'b0;
`endif

   // Ports drop wen when idle but keep addr/data so the regfile inputs stay quiet.
   always_comb begin
      wr0_d     = wr0_q;
      wr0_d.wen = 1'b0;
      wr1_d     = wr1_q;
      wr1_d.wen = 1'b0;
      if (grant_en && p0_vld) wr0_d = cand[p0_src];
      if (grant_en && p1_vld) wr1_d = cand[p1_src];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         wr0_q      <= '0;
         wr1_q      <= '0;
         wen_bank_q <= 1'b0;
         wr_bank_q  <= '0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         wr0_q      <= wr0_d;
         wr1_q      <= wr1_d;
         wen_bank_q <= 1'b0;
         wr_bank_q  <= '0;
         ack_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bank_sw_req_i) begin
                  state_q <= DRAIN;
                  busy_q  <= 1'b1;
               end
            end
            DRAIN: begin
               state_q    <= SWITCH;
               wen_bank_q <= 1'b1;
               wr_bank_q  <= bank_sw_id_i;
            end
            SWITCH: begin
               state_q <= ACK;
               ack_q   <= 1'b1;
            end
            ACK: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wen0_o        = wr0_q.wen;
   assign waddr0_o      = wr0_q.addr;
   assign wd0_o         = FLEN'(wr0_q.data);
   assign wen1_o        = wr1_q.wen;
   assign waddr1_o      = wr1_q.addr;
   assign wd1_o         = FLEN'(wr1_q.data);
   assign wen_bank_id_o = wen_bank_q;
   assign wr_bank_id_o  = wr_bank_q;
   assign bank_sw_ack_o = ack_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_fpr_wb_arb.sv
// Directed bench for fpr_wb_arb: vector table for grant/priority, hand sequences for
// bank switch, back-to-back switch, reset mid-switch and (with FPR_WB_STARVE_EN) starvation.
module tb_fpr_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid, ld_ready, fpu_valid, fpu_ready, div_valid, div_ready;
   logic [4:0]  ld_addr, fpu_addr, div_addr;
   logic [63:0] ld_data, fpu_data, div_data;
   logic        bank_sw_req, bank_sw_ack;
   logic [0:0]  bank_sw_id, wr_bank_id;
   logic        wen0, wen1, wen_bank_id, busy;
   logic [4:0]  waddr0, waddr1;
   logic [63:0] wd0, wd1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fpr_wb_arb #(.FLEN(64), .FPR_BANKS_LOG2(1), .STARVE_LIMIT(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
      .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_addr_i(fpu_addr), .fpu_data_i(fpu_data),
      .div_valid_i(div_valid), .div_ready_o(div_ready), .div_addr_i(div_addr), .div_data_i(div_data),
      .bank_sw_req_i(bank_sw_req), .bank_sw_id_i(bank_sw_id), .bank_sw_ack_o(bank_sw_ack),
      .wen0_o(wen0), .wen1_o(wen1), .waddr0_o(waddr0), .waddr1_o(waddr1), .wd0_o(wd0), .wd1_o(wd1),
      .wen_bank_id_o(wen_bank_id), .wr_bank_id_o(wr_bank_id), .busy_o(busy)
   );

   typedef struct {
      logic        lv;  logic [4:0] la;  logic [63:0] ld;
      logic        fv;  logic [4:0] fa;  logic [63:0] fd;
      logic        dv;  logic [4:0] da;  logic [63:0] dd;
      logic [2:0]  rdy;                  // {ld, fpu, div}
      logic        w0;  logic [4:0] a0;  logic [63:0] d0;
      logic        w1;  logic [4:0] a1;  logic [63:0] d1;
   } vec_t;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   vec_t vt [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_srcs();
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      fpu_valid = 0; fpu_addr = 0; fpu_data = 0;
      div_valid = 0; div_addr = 0; div_data = 0;
   endtask

   initial begin
      vt[0]  = '{T,5'd3,64'h0123_4567_89AB_CDEF, T,5'd5,64'hFEDC_BA98_7654_3210, F,5'd0,64'h0,
                 3'b110, T,5'd3,64'h0123_4567_89AB_CDEF, T,5'd5,64'hFEDC_BA98_7654_3210};
      vt[1]  = '{T,5'd1,64'h11, T,5'd2,64'h22, T,5'd4,64'h44, 3'b110, T,5'd1,64'h11, T,5'd2,64'h22};
      vt[2]  = '{F,5'd0,64'h0,  F,5'd0,64'h0,  T,5'd4,64'h44, 3'b001, T,5'd4,64'h44, F,5'd2,64'h22};
      vt[3]  = '{T,5'd7,64'hD1, T,5'd7,64'hD2, F,5'd0,64'h0,  3'b100, T,5'd7,64'hD1, F,5'd2,64'h22};
      vt[4]  = '{F,5'd0,64'h0,  T,5'd7,64'hD2, F,5'd0,64'h0,  3'b010, T,5'd7,64'hD2, F,5'd2,64'h22};
      vt[5]  = '{F,5'd0,64'h0,  F,5'd0,64'h0,  F,5'd0,64'h0,  3'b000, F,5'd7,64'hD2, F,5'd2,64'h22};
      vt[6]  = '{F,5'd0,64'h0,  T,5'd0,64'hE0, T,5'd0,64'hF0, 3'b010, T,5'd0,64'hE0, F,5'd2,64'h22};
      vt[7]  = '{F,5'd0,64'h0,  F,5'd0,64'h0,  T,5'd0,64'hF0, 3'b001, T,5'd0,64'hF0, F,5'd2,64'h22};
      vt[8]  = '{T,5'd9,64'h99, F,5'd0,64'h0,  T,5'd12,64'hCC, 3'b101, T,5'd9,64'h99, T,5'd12,64'hCC};
      vt[9]  = '{F,5'd0,64'h0,  T,5'd31,64'h31, T,5'd30,64'h30, 3'b011, T,5'd31,64'h31, T,5'd30,64'h30};
      vt[10] = '{T,5'd6,64'hA6, T,5'd6,64'hB6, T,5'd6,64'hC6, 3'b100, T,5'd6,64'hA6, F,5'd30,64'h30};
      vt[11] = '{F,5'd0,64'h0,  T,5'd6,64'hB6, T,5'd8,64'hC8, 3'b011, T,5'd6,64'hB6, T,5'd8,64'hC8};

      // Reset: outputs zero even with a source asserting valid.
      rst = 1; bank_sw_req = 0; bank_sw_id = 0;
      idle_srcs();
      ld_valid = 1; ld_addr = 5'd9;
      tick(); tick();
      chk("rst ld_ready", ld_ready, 0);
      chk("rst wen0", wen0, 0);
      chk("rst waddr0", waddr0, 0);
      chk("rst wd1", wd1, 0);
      chk("rst busy", busy, 0);
      chk("rst ack", bank_sw_ack, 0);
      chk("rst wen_bank_id", wen_bank_id, 0);
      rst = 0;
      idle_srcs();
      tick();

      for (int i = 0; i < 12; i++) begin
         ld_valid = vt[i].lv; ld_addr = vt[i].la; ld_data = vt[i].ld;
         fpu_valid = vt[i].fv; fpu_addr = vt[i].fa; fpu_data = vt[i].fd;
         div_valid = vt[i].dv; div_addr = vt[i].da; div_data = vt[i].dd;
         #1;
         chk($sformatf("v%0d ld_ready", i), ld_ready, vt[i].rdy[2]);
         chk($sformatf("v%0d fpu_ready", i), fpu_ready, vt[i].rdy[1]);
         chk($sformatf("v%0d div_ready", i), div_ready, vt[i].rdy[0]);
         tick();
         chk($sformatf("v%0d wen0", i), wen0, vt[i].w0);
         chk($sformatf("v%0d waddr0", i), waddr0, vt[i].a0);
         chk($sformatf("v%0d wd0", i), wd0, vt[i].d0);
         chk($sformatf("v%0d wen1", i), wen1, vt[i].w1);
         chk($sformatf("v%0d waddr1", i), waddr1, vt[i].a1);
         chk($sformatf("v%0d wd1", i), wd1, vt[i].d1);
      end

      // Bank switch while fpu streams.
      idle_srcs();
      fpu_valid = 1; fpu_addr = 5'd10; fpu_data = 64'h100;
      #1 chk("sw pre fpu_ready", fpu_ready, 1);
      tick();
      fpu_addr = 5'd11; fpu_data = 64'h101;
      bank_sw_req = 1; bank_sw_id = 1;
      #1;
      chk("sw decide fpu_ready", fpu_ready, 0);
      chk("sw decide wen0 last write", wen0, 1);
      chk("sw decide waddr0", waddr0, 5'd10);
      tick();
      chk("sw drain busy", busy, 1);
      chk("sw drain wen0", wen0, 0);
      chk("sw drain fpu_ready", fpu_ready, 0);
      chk("sw drain wen_bank_id", wen_bank_id, 0);
      tick();
      chk("sw switch wen_bank_id", wen_bank_id, 1);
      chk("sw switch wr_bank_id", wr_bank_id, 1);
      chk("sw switch wen0", wen0, 0);
      chk("sw switch ack", bank_sw_ack, 0);
      tick();
      chk("sw ack pulse", bank_sw_ack, 1);
      chk("sw ack wen_bank_id", wen_bank_id, 0);
      chk("sw ack fpu_ready", fpu_ready, 0);
      chk("sw ack busy", busy, 1);
      bank_sw_req = 0;
      tick();
      chk("sw idle ack", bank_sw_ack, 0);
      chk("sw idle busy", busy, 0);
      chk("sw idle fpu_ready", fpu_ready, 1);
      tick();
      chk("sw resume wen0", wen0, 1);
      chk("sw resume waddr0", waddr0, 5'd11);
      chk("sw resume wd0", wd0, 64'h101);
      idle_srcs();

      // Request held past ACK starts a second switch; reset lands in its SWITCH.
      bank_sw_req = 1; bank_sw_id = 1;
      tick(); tick(); tick();
      chk("b2b ack", bank_sw_ack, 1);
      fpu_valid = 1; fpu_addr = 5'd12; fpu_data = 64'h200;
      tick();
      chk("b2b idle fpu_ready", fpu_ready, 0);
      tick();
      chk("b2b drain busy", busy, 1);
      tick();
      chk("b2b switch wen_bank_id", wen_bank_id, 1);
      rst = 1;
      tick();
      chk("midrst wen_bank_id", wen_bank_id, 0);
      chk("midrst wr_bank_id", wr_bank_id, 0);
      chk("midrst ack", bank_sw_ack, 0);
      chk("midrst busy", busy, 0);
      chk("midrst wen0", wen0, 0);
      chk("midrst fpu_ready", fpu_ready, 0);
      rst = 0; bank_sw_req = 0;
      idle_srcs();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("midrst no ack c%0d", k), bank_sw_ack, 0);
      end

`ifdef FPR_WB_STARVE_EN
      ld_valid = 1; ld_addr = 5'd1; ld_data = 64'h1D;
      fpu_valid = 1; fpu_addr = 5'd2; fpu_data = 64'h2F;
      div_valid = 1; div_addr = 5'd3; div_data = 64'h3D;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk($sformatf("starve div_ready w%0d", k), div_ready, (k == 8) ? 1'b1 : 1'b0);
         if (k == 8) begin
            chk("starve ld_ready", ld_ready, 1);
            chk("starve fpu_ready", fpu_ready, 0);
         end
         tick();
      end
      chk("starve waddr0", waddr0, 5'd3);
      chk("starve wd0", wd0, 64'h3D);
      chk("starve waddr1", waddr1, 5'd1);
      idle_srcs();
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
